// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin arbiter that feeds one uart_tx from four byte requesters.
// Latency: 1 clock from a pending request seen in IDLE to o_TX_DV / o_Req_Ack.
// Backpressure: requesters hold valid+byte until acked; nothing is accepted during a frame or guard gap.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add a watchdog on i_TX_Done.
// Without it WAIT_DONE waits forever and o_Timeout is tied low.
//
// Ports:
//   i_Clock, i_Rst_L      clock, asynchronous active-low reset
//   i_Req_Valid[3:0]      per-requester byte pending
//   i_Req_Byte[31:0]      requester k byte at [8k+7:8k]
//   o_Req_Ack[3:0]        one-hot single-cycle accept pulse
//   o_Grant_Id[1:0]       requester currently being served
//   o_Busy                high whenever not IDLE
//   o_TX_DV, o_TX_Byte    start pulse and byte to uart_tx
//   i_TX_Active           uart_tx status (informational only)
//   i_TX_Done             uart_tx frame-complete pulse
//   o_Timeout             single-cycle watchdog expiry pulse
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CLKS   = 0,
  parameter int TIMEOUT_CLKS = 2400
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic [1:0]           o_Grant_Id,
  output logic                 o_Busy,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done,
  output logic                 o_Timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GUARD     = 2'd2
  } state_t;

  // Wraps to 16'hFFFF when GUARD_CLKS is 0; GUARD is never entered then.
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CLKS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_grant;
  logic [15:0] guard_cnt;
  logic        sel_found;
  logic [1:0]  sel_id;
  logic [1:0]  cand;
  logic        load;
  logic        to_expire;

  // Status input is not needed for sequencing; kept for connectivity.
  logic unused_tx_active;
  assign unused_tx_active = i_TX_Active;

  // Round-robin search starting just after the last grant; the 4th step
  // revisits last_grant itself, so a continuously-valid winner is served last.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!sel_found && i_Req_Valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          load      = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A done pulse wins over a watchdog expiry in the same cycle.
        if (i_TX_Done) begin
          state_nxt = (GUARD_CLKS > 0) ? GUARD : IDLE;
        end else if (to_expire) begin
          state_nxt = IDLE;
        end
      end
      GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Guard counter counts GUARD cycles from 0, so GUARD lasts GUARD_CLKS cycles.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      guard_cnt <= 16'd0;
    end else if (state == GUARD) begin
      guard_cnt <= guard_cnt + 16'd1;
    end else begin
      guard_cnt <= 16'd0;
    end
  end

  // Byte and grant id are only written on a load, so they stay stable for the
  // whole frame and guard gap.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_TX_DV    <= 1'b0;
      o_Req_Ack  <= '0;
      o_TX_Byte  <= 8'h00;
      o_Grant_Id <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      o_TX_DV   <= load;
      o_Req_Ack <= load ? (NUM_REQ'(1) << sel_id) : '0;
      if (load) begin
        o_TX_Byte  <= i_Req_Byte[{sel_id, 3'b000} +: 8];
        o_Grant_Id <= sel_id;
        last_grant <= sel_id;
      end
    end
  end

  assign o_Busy = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Counter is 0 on the first WAIT_DONE cycle, so expiry is flagged in the
  // TIMEOUT_CLKS-th cycle and o_Timeout shows one clock later, with IDLE.
  assign to_expire = (state == WAIT_DONE) && !i_TX_Done &&
                     (to_cnt == 32'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      to_cnt    <= 32'd0;
      o_Timeout <= 1'b0;
    end else begin
      o_Timeout <= to_expire;
      if (state == WAIT_DONE) begin
        to_cnt <= to_cnt + 32'd1;
      end else begin
        to_cnt <= 32'd0;
      end
    end
  end
`else
  assign to_expire = 1'b0;
  assign o_Timeout = 1'b0;
`endif

endmodule
